// File: rtl/frame_stream_checker.sv
// Raster-order checker with per-lane additive checksums and a clean-frame counter.
// Optional watchdog enabled by defining FRAME_TIMEOUT_EN.

module fsc_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  add,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           checksum
);
    logic [31:0] acc;
    logic [31:0] sum_n;

    // The closing beat's data is part of the frame, so publish the post-add sum.
    assign sum_n = load ? 32'(data) : acc + 32'(data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            checksum <= '0;
        end else if (clear) begin
            acc      <= '0;
            checksum <= '0;
        end else begin
            if (load || add) acc <= sum_n;
            if (done) checksum <= sum_n;
        end
    end
endmodule

module frame_stream_checker #(
    parameter int IMAGE_WIDTH    = 512,
    parameter int IMAGE_HEIGHT   = 400,
    parameter int CHANNELS       = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int COORD_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clear_i,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  data_i,
    input  logic [COORD_WIDTH-1:0]               col_i,
    input  logic [COORD_WIDTH-1:0]               row_i,
    input  logic                                 valid_i,
    output logic                                 frame_done_o,
    output logic [31:0]                          frame_count_o,
    output logic [CHANNELS-1:0][31:0]            checksum_o,
    output logic                                 seq_error_o,
    output logic [COORD_WIDTH-1:0]               err_col_o,
    output logic [COORD_WIDTH-1:0]               err_row_o,
    output logic                                 timeout_o
);
    typedef enum logic [1:0] {IDLE, IN_FRAME, RESYNC} state_t;

    localparam logic [COORD_WIDTH-1:0] LAST_COL = COORD_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_ROW = COORD_WIDTH'(IMAGE_HEIGHT - 1);

    state_t                 state, state_n;
    logic [COORD_WIDTH-1:0] exp_col, exp_row, exp_col_n, exp_row_n;
    logic [COORD_WIDTH-1:0] adv_col, adv_row;
    logic                   at_origin, at_end, at_exp;
    logic                   load, add, done, err, tmo;

    assign at_origin = (col_i == '0) && (row_i == '0);
    assign at_end    = (col_i == LAST_COL) && (row_i == LAST_ROW);
    assign at_exp    = (col_i == exp_col) && (row_i == exp_row);
    assign adv_col   = (col_i == LAST_COL) ? '0 : col_i + 1'b1;
    assign adv_row   = (col_i == LAST_COL) ? row_i + 1'b1 : row_i;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          timeout_q;

    assign tmo       = (state == IN_FRAME) && !valid_i && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else if (clear_i) begin
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != IN_FRAME || valid_i || tmo) tcnt <= '0;
            else                                     tcnt <= tcnt + 1'b1;
            if (tmo) timeout_q <= 1'b1;
        end
    end
`else
    assign tmo       = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        exp_col_n = exp_col;
        exp_row_n = exp_row;
        load      = 1'b0;
        add       = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE, RESYNC: begin
                if (valid_i && at_origin) begin
                    load      = 1'b1;
                    exp_col_n = adv_col;
                    exp_row_n = adv_row;
                    // A 1x1 image closes on its opening beat.
                    if (at_end) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = IN_FRAME;
                    end
                end
            end
            IN_FRAME: begin
                if (valid_i) begin
                    if (at_exp) begin
                        add       = 1'b1;
                        exp_col_n = adv_col;
                        exp_row_n = adv_row;
                        if (at_end) begin
                            done    = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        err     = 1'b1;
                        state_n = RESYNC;
                    end
                end else if (tmo) begin
                    state_n = RESYNC;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            exp_col       <= '0;
            exp_row       <= '0;
            frame_done_o  <= 1'b0;
            frame_count_o <= '0;
            seq_error_o   <= 1'b0;
            err_col_o     <= '0;
            err_row_o     <= '0;
        end else if (clear_i) begin
            state         <= IDLE;
            exp_col       <= '0;
            exp_row       <= '0;
            frame_done_o  <= 1'b0;
            frame_count_o <= '0;
            seq_error_o   <= 1'b0;
            err_col_o     <= '0;
            err_row_o     <= '0;
        end else begin
            state        <= state_n;
            exp_col      <= exp_col_n;
            exp_row      <= exp_row_n;
            frame_done_o <= done;
            if (done) frame_count_o <= frame_count_o + 32'd1;
            if (err) begin
                seq_error_o <= 1'b1;
                // Only the first offending beat is kept for debug.
                if (!seq_error_o) begin
                    err_col_o <= col_i;
                    err_row_o <= row_i;
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        fsc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk      (clk_i),
            .rst      (rst_i),
            .clear    (clear_i),
            .load     (load),
            .add      (add),
            .done     (done),
            .data     (data_i[k]),
            .checksum (checksum_o[k])
        );
    end
endmodule
